// File: rtl/itype_seq_ctrl_if.sv
// Instruction handshake bundle between an instruction source and itype_seq_ctrl.
// Word layout: [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] imm.
interface itype_seq_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/itype_seq_ctrl.sv
// Multi-cycle IDLE/DECODE/EXECUTE/WRITEBACK sequencer for MIPS I-type ALU instructions.
// Define ITYPE_RETIRE_CNT_EN to add the retire_cnt port counting register-writing retirements.
module itype_seq_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    itype_seq_ctrl_if.slave  ibus,
    output logic [RF_AW-1:0] rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_ovf,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             done,
    output logic             exc_ovf,
    output logic             exc_ill
`ifdef ITYPE_RETIRE_CNT_EN
    ,
    output logic [31:0]      retire_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StDecode, StExecute, StWriteback} state_e;

    state_e           state;
    logic [5:0]       op_q;
    logic [RF_AW-1:0] rt_q;
    logic [15:0]      imm_q;

    logic             dec_legal;
    logic             dec_sext;
    logic [3:0]       dec_ctrl;
    logic [XLEN-1:0]  dec_imm;
    logic             is_addi;
    logic             addi_ovf;

    always_comb begin
        dec_legal = 1'b1;
        dec_sext  = 1'b0;
        dec_ctrl  = 4'b0000;
        case (op_q)
            6'h08:   begin dec_ctrl = 4'b0010; dec_sext = 1'b1; end
            6'h0C:   dec_ctrl = 4'b0000;
            6'h0D:   dec_ctrl = 4'b0001;
            6'h0A:   begin dec_ctrl = 4'b0111; dec_sext = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
        dec_imm = dec_sext ? {{(XLEN-16){imm_q[15]}}, imm_q} : {{(XLEN-16){1'b0}}, imm_q};
    end

    assign is_addi  = (op_q == 6'h08);
    // Only addi traps on overflow; the other opcodes ignore alu_ovf.
    assign addi_ovf = is_addi & alu_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= StIdle;
            ibus.instr_ready <= 1'b1;
            op_q             <= '0;
            rt_q             <= '0;
            imm_q            <= '0;
            rf_raddr         <= '0;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_ctrl         <= '0;
            rf_we            <= 1'b0;
            rf_waddr         <= '0;
            rf_wdata         <= '0;
            done             <= 1'b0;
            exc_ovf          <= 1'b0;
            exc_ill          <= 1'b0;
`ifdef ITYPE_RETIRE_CNT_EN
            retire_cnt       <= '0;
`endif
        end else begin
            rf_we   <= 1'b0;
            done    <= 1'b0;
            exc_ovf <= 1'b0;
            exc_ill <= 1'b0;
            case (state)
                StIdle: begin
                    if (ibus.instr_valid) begin
                        op_q             <= ibus.instr[31:26];
                        rt_q             <= ibus.instr[16 +: RF_AW];
                        imm_q            <= ibus.instr[15:0];
                        rf_raddr         <= ibus.instr[21 +: RF_AW];
                        ibus.instr_ready <= 1'b0;
                        state            <= StDecode;
                    end
                end
                StDecode: begin
                    rf_raddr <= '0;
                    if (dec_legal) begin
                        alu_a    <= rf_rdata;
                        alu_b    <= dec_imm;
                        alu_ctrl <= dec_ctrl;
                        state    <= StExecute;
                    end else begin
                        done     <= 1'b1;
                        exc_ill  <= 1'b1;
                        rf_waddr <= rt_q;
                        state    <= StWriteback;
                    end
                end
                StExecute: begin
                    alu_a    <= '0;
                    alu_b    <= '0;
                    alu_ctrl <= '0;
                    done     <= 1'b1;
                    exc_ovf  <= addi_ovf;
                    rf_we    <= (rt_q != '0) && !addi_ovf;
                    rf_waddr <= rt_q;
                    rf_wdata <= alu_result;
                    state    <= StWriteback;
                end
                StWriteback: begin
                    rf_waddr         <= '0;
                    rf_wdata         <= '0;
                    ibus.instr_ready <= 1'b1;
                    state            <= StIdle;
`ifdef ITYPE_RETIRE_CNT_EN
                    if (rf_we) retire_cnt <= retire_cnt + 32'd1;
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/itype_seq_ctrl.md
Name: itype_seq_ctrl

Overview:
- Multi-cycle sequencer that drives the shared 32-bit ALU and 32x32 register file for MIPS I-type arithmetic/logic instructions.
- Accepts one 32-bit instruction word per valid/ready handshake and decodes it.
- Steps through DECODE, EXECUTE and WRITEBACK.
- Generates register-file read/write strobes, the ALU operands and the 4-bit ALU control code; reports completion, overflow and illegal opcodes.

Parameters:
- XLEN, 32, data width of register file and ALU operands
- RF_AW, 5, register-file address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction word present
- instr_ready  out  1  controller can accept an instruction
- instr  in  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] imm
- rf_raddr  out  RF_AW  register-file read address (combinational read)
- rf_rdata  in  XLEN  register-file read data
- alu_a  out  XLEN  ALU operand A
- alu_b  out  XLEN  ALU operand B (extended immediate)
- alu_ctrl  out  4  ALU control code
- alu_result  in  XLEN  ALU result
- alu_ovf  in  1  ALU signed overflow
- rf_we  out  1  register-file write enable, one-cycle pulse
- rf_waddr  out  RF_AW  write address (rt)
- rf_wdata  out  XLEN  write data
- done  out  1  one-cycle pulse when an instruction retires
- exc_ovf  out  1  qualifies done: addi overflow, write suppressed
- exc_ill  out  1  qualifies done: unsupported opcode, write suppressed

Behaviour:
- Reset (rst_n=0, async): state=IDLE; instr_ready=1; all other outputs 0, including internal latches.
- States: IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE.
- IDLE:
  - instr_ready=1.
  - On a clock edge with instr_valid=1, latch instr and go to DECODE.
  - instr_ready is 0 in every other state; valid without ready is held off (no loss).
- DECODE:
  - rf_raddr=rs; rf_rdata is latched as operand A at the end of the cycle.
  - Decode table:
    - 0x08 addi: sign-extend imm, alu_ctrl=0010
    - 0x0C andi: zero-extend imm, alu_ctrl=0000
    - 0x0D ori: zero-extend imm, alu_ctrl=0001
    - 0x0A slti: sign-extend imm, alu_ctrl=0111
  - Any other opcode: go directly to WRITEBACK with the illegal flag set.
- EXECUTE:
  - alu_a, alu_b and alu_ctrl are driven stable for the whole cycle.
  - alu_result and alu_ovf are latched at the end of the cycle.
  - alu_a, alu_b and alu_ctrl are 0 in every state other than EXECUTE.
- WRITEBACK:
  - done=1 for exactly one cycle; rf_waddr=rt; rf_wdata=latched result.
  - rf_we=1 only when: opcode is legal, rt!=0, and not (addi with overflow).
  - exc_ovf=1 only for addi with alu_ovf=1 (andi, ori and slti ignore alu_ovf).
  - exc_ill=1 for an illegal opcode.
  - The next state is always IDLE.
- Latency:
  - Legal instruction: accept edge -> done asserted 3 cycles later.
  - Illegal instruction: 2 cycles.
  - Throughput: one instruction per 4 cycles (legal) or per 3 cycles (illegal).
- rs==rt: the read happens in DECODE and the write in WRITEBACK, so there is no hazard.
- Reset mid-instruction: the instruction is abandoned with no write and no done; the FSM returns to IDLE.
- The rf_we, done and exc_* pulses never last longer than one cycle.

Optional Feature:
- Macro: ITYPE_RETIRE_CNT_EN.
- Enabled:
  - Adds output port retire_cnt [31:0], reset to 0.
  - Increments by 1 on every done pulse that has rf_we=1, wrapping 0xFFFFFFFF -> 0.
  - Exception and rt=0 retirements are not counted.
- Disabled: the port and counter are absent; all other behaviour is identical.

Test Plan:
- addi r5,r1,0xFFFF with rf_rdata=1 -> ALU sees alu_a=1, alu_b=0xFFFFFFFF, alu_ctrl=0010; with alu_result=0 -> rf_we=1, rf_waddr=5, rf_wdata=0; done 3 cycles after accept.
- ori r3,r2,0x8000 with rf_rdata=0x00000001 -> alu_b=0x00008000 (zero-extended), alu_ctrl=0001; rf_wdata is the returned alu_result.
- addi with alu_ovf=1 (rs=0x7FFFFFFF, imm=1) -> done=1, exc_ovf=1, rf_we=0.
- Opcode 0x3F -> done 2 cycles after accept, exc_ill=1, rf_we=0; instr_ready returns to 1 on the next cycle.
- andi r0,r4,0x00FF -> done=1, rf_we=0, exc_ovf=exc_ill=0.
- Edge cases:
  - Hold instr_valid high for two back-to-back instructions -> second accepted only in IDLE, 4 cycles after the first.
  - Drop rst_n during EXECUTE -> outputs zero immediately, no rf_we/done.
  - With ITYPE_RETIRE_CNT_EN: three legal writes -> retire_cnt=3.
